// File: rtl/pulse_analyzer.sv
// Receive-side pulse train analyser: synchronises i_pulse, measures high time and
// period per cycle of the train, reports each completed period, tracks lock and timeout.
module pulse_analyzer #(
   parameter int unsigned CNT_W        = 7,
   parameter int unsigned EXP_DURATION = 3,
   parameter int unsigned EXP_PERIOD   = 7,
   parameter int unsigned TIMEOUT      = 127,
   parameter int unsigned LOCK_COUNT   = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_pulse,
   output logic [CNT_W-1:0] o_duration,
   output logic [CNT_W-1:0] o_period,
   output logic             o_valid,
   output logic             o_match,
   output logic             o_lock,
   output logic             o_timeout
);

   localparam logic [CNT_W-1:0] DUR_C   = CNT_W'(EXP_DURATION);
   localparam logic [CNT_W-1:0] PER_C   = CNT_W'(EXP_PERIOD);
   localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
   localparam logic [3:0]       LOCK_C  = 4'(LOCK_COUNT);

   typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

   state_t           state;
   logic             sync1, s, s_d;
   logic             rise, fall;
   logic [CNT_W-1:0] hi_cnt, per_cnt;
   logic [3:0]       match_cnt, match_nxt;
   logic             is_match, at_limit;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync1 <= 1'b0;
         s     <= 1'b0;
         s_d   <= 1'b0;
      end else begin
         sync1 <= i_pulse;
         s     <= sync1;
         s_d   <= s;
      end
   end

   always_comb begin
      rise      = s & ~s_d;
      fall      = ~s & s_d;
      is_match  = (hi_cnt == DUR_C) && (per_cnt == PER_C);
      at_limit  = (per_cnt == LIMIT_C);
      match_nxt = '0;
      if (is_match)
         match_nxt = (match_cnt == LOCK_C) ? match_cnt : match_cnt + 4'd1;
   end

   // A rise on the TIMEOUT cycle still closes the period normally, so rise is tested first.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state      <= IDLE;
         hi_cnt     <= '0;
         per_cnt    <= '0;
         match_cnt  <= '0;
         o_duration <= '0;
         o_period   <= '0;
         o_valid    <= 1'b0;
         o_match    <= 1'b0;
         o_lock     <= 1'b0;
         o_timeout  <= 1'b0;
      end else begin
         o_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (rise) begin
                  state     <= HIGH;
                  hi_cnt    <= ONE_C;
                  per_cnt   <= ONE_C;
                  o_timeout <= 1'b0;
               end
            end
            HIGH, LOW: begin
               if (rise) begin
                  o_duration <= hi_cnt;
                  o_period   <= per_cnt;
                  o_match    <= is_match;
                  o_valid    <= 1'b1;
                  match_cnt  <= match_nxt;
                  o_lock     <= (match_nxt == LOCK_C);
                  hi_cnt     <= ONE_C;
                  per_cnt    <= ONE_C;
                  state      <= HIGH;
               end else if (at_limit) begin
                  state     <= IDLE;
                  o_timeout <= 1'b1;
                  match_cnt <= '0;
                  o_lock    <= 1'b0;
               end else begin
                  per_cnt <= per_cnt + ONE_C;
                  if (state == HIGH && s)
                     hi_cnt <= hi_cnt + ONE_C;
                  if (state == HIGH && fall)
                     state <= LOW;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pulse_analyzer.sv
// Directed bench for pulse_analyzer: drives pulse trains period by period and checks
// every report (values, spacing, lock) plus reset, timeout and period-limit behaviour.
module tb_pulse_analyzer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       i_pulse = 1'b0;
   logic [6:0] o_duration, o_period;
   logic       o_valid, o_match, o_lock, o_timeout;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int ph[$], pl[$];
   int q_dur[$], q_per[$], q_match[$], q_lock[$], q_cyc[$];

   pulse_analyzer #(
      .CNT_W(7), .EXP_DURATION(3), .EXP_PERIOD(7), .TIMEOUT(127), .LOCK_COUNT(4)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_pulse(i_pulse),
      .o_duration(o_duration), .o_period(o_period), .o_valid(o_valid),
      .o_match(o_match), .o_lock(o_lock), .o_timeout(o_timeout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (rst_n && o_valid) begin
         q_dur.push_back(int'(o_duration));
         q_per.push_back(int'(o_period));
         q_match.push_back(int'(o_match));
         q_lock.push_back(int'(o_lock));
         q_cyc.push_back(cyc);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish before 1ms");
      $fatal(1, "watchdog expired");
   end

   task automatic clear_q();
      q_dur = {}; q_per = {}; q_match = {}; q_lock = {}; q_cyc = {};
   endtask

   task automatic do_reset();
      @(negedge clk) rst_n = 1'b0;
      i_pulse = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      clear_q();
   endtask

   // Plays periods ph/pl from index first onward, then a closing rise so the last period reports.
   task automatic play(input int first);
      for (int k = first; k < ph.size(); k++) begin
         @(negedge clk) i_pulse = 1'b1;
         repeat (ph[k] - 1) @(negedge clk);
         @(negedge clk) i_pulse = 1'b0;
         repeat (pl[k] - 1) @(negedge clk);
      end
      @(negedge clk) i_pulse = 1'b1;
      repeat (5) @(negedge clk);
   endtask

   task automatic test_reset();
      #1;
      checks += 6;
      if (o_duration !== 7'd0) begin errors++; $display("FAIL reset dur: got %0d expected 0", o_duration); end
      if (o_period !== 7'd0) begin errors++; $display("FAIL reset per: got %0d expected 0", o_period); end
      if (o_valid !== 1'b0) begin errors++; $display("FAIL reset valid: got %0b expected 0", o_valid); end
      if (o_match !== 1'b0) begin errors++; $display("FAIL reset match: got %0b expected 0", o_match); end
      if (o_lock !== 1'b0) begin errors++; $display("FAIL reset lock: got %0b expected 0", o_lock); end
      if (o_timeout !== 1'b0) begin errors++; $display("FAIL reset timeout: got %0b expected 0", o_timeout); end
   endtask

   task automatic test_lock();
      string tag = "lock37";
      int ep, em, mc;
      do_reset();
      ph = {3, 3, 3, 3, 3, 3, 3, 3, 3, 3};
      pl = {4, 4, 4, 4, 4, 4, 4, 4, 4, 4};
      play(0);
      mc = 0;
      checks++;
      if (q_per.size() !== ph.size()) begin errors++; $display("FAIL %s count: got %0d expected %0d", tag, q_per.size(), ph.size()); end
      for (int i = 0; i < q_per.size() && i < ph.size(); i++) begin
         ep = ph[i] + pl[i];
         em = (ph[i] == 3 && ep == 7) ? 1 : 0;
         mc = em ? ((mc < 4) ? mc + 1 : 4) : 0;
         checks += 4;
         if (q_dur[i] !== ph[i]) begin errors++; $display("FAIL %s dur[%0d]: got %0d expected %0d", tag, i, q_dur[i], ph[i]); end
         if (q_per[i] !== ep) begin errors++; $display("FAIL %s per[%0d]: got %0d expected %0d", tag, i, q_per[i], ep); end
         if (q_match[i] !== em) begin errors++; $display("FAIL %s match[%0d]: got %0d expected %0d", tag, i, q_match[i], em); end
         if (q_lock[i] !== int'(mc == 4)) begin errors++; $display("FAIL %s lock[%0d]: got %0d expected %0d", tag, i, q_lock[i], mc == 4); end
         if (i > 0) begin
            checks++;
            if (q_cyc[i] - q_cyc[i-1] !== ep) begin errors++; $display("FAIL %s gap[%0d]: got %0d expected %0d", tag, i, q_cyc[i] - q_cyc[i-1], ep); end
         end
      end
   endtask

   task automatic test_mismatch();
      string tag = "mismatch25";
      int ep, em, mc;
      do_reset();
      ph = {2, 2, 2, 2, 2, 2, 3, 3, 3, 3, 3};
      pl = {3, 3, 3, 3, 3, 3, 4, 4, 4, 4, 4};
      play(0);
      mc = 0;
      checks++;
      if (q_per.size() !== ph.size()) begin errors++; $display("FAIL %s count: got %0d expected %0d", tag, q_per.size(), ph.size()); end
      for (int i = 0; i < q_per.size() && i < ph.size(); i++) begin
         ep = ph[i] + pl[i];
         em = (ph[i] == 3 && ep == 7) ? 1 : 0;
         mc = em ? ((mc < 4) ? mc + 1 : 4) : 0;
         checks += 4;
         if (q_dur[i] !== ph[i]) begin errors++; $display("FAIL %s dur[%0d]: got %0d expected %0d", tag, i, q_dur[i], ph[i]); end
         if (q_per[i] !== ep) begin errors++; $display("FAIL %s per[%0d]: got %0d expected %0d", tag, i, q_per[i], ep); end
         if (q_match[i] !== em) begin errors++; $display("FAIL %s match[%0d]: got %0d expected %0d", tag, i, q_match[i], em); end
         if (q_lock[i] !== int'(mc == 4)) begin errors++; $display("FAIL %s lock[%0d]: got %0d expected %0d", tag, i, q_lock[i], mc == 4); end
         if (i > 0) begin
            checks++;
            if (q_cyc[i] - q_cyc[i-1] !== ep) begin errors++; $display("FAIL %s gap[%0d]: got %0d expected %0d", tag, i, q_cyc[i] - q_cyc[i-1], ep); end
         end
      end
   endtask

   task automatic test_stretch();
      string tag = "stretch8";
      int ep, em, mc;
      do_reset();
      ph = {3, 3, 3, 3, 3, 3, 3, 3, 3, 3};
      pl = {4, 4, 4, 4, 4, 5, 4, 4, 4, 4};
      play(0);
      mc = 0;
      checks++;
      if (q_per.size() !== ph.size()) begin errors++; $display("FAIL %s count: got %0d expected %0d", tag, q_per.size(), ph.size()); end
      for (int i = 0; i < q_per.size() && i < ph.size(); i++) begin
         ep = ph[i] + pl[i];
         em = (ph[i] == 3 && ep == 7) ? 1 : 0;
         mc = em ? ((mc < 4) ? mc + 1 : 4) : 0;
         checks += 4;
         if (q_dur[i] !== ph[i]) begin errors++; $display("FAIL %s dur[%0d]: got %0d expected %0d", tag, i, q_dur[i], ph[i]); end
         if (q_per[i] !== ep) begin errors++; $display("FAIL %s per[%0d]: got %0d expected %0d", tag, i, q_per[i], ep); end
         if (q_match[i] !== em) begin errors++; $display("FAIL %s match[%0d]: got %0d expected %0d", tag, i, q_match[i], em); end
         if (q_lock[i] !== int'(mc == 4)) begin errors++; $display("FAIL %s lock[%0d]: got %0d expected %0d", tag, i, q_lock[i], mc == 4); end
      end
   endtask

   task automatic test_timeout_low();
      do_reset();
      ph = {3, 3, 3, 3, 3};
      pl = {4, 4, 4, 4, 4};
      play(0);
      checks += 2;
      if (q_per.size() !== 5) begin errors++; $display("FAIL tlow pre count: got %0d expected 5", q_per.size()); end
      if (o_lock !== 1'b1) begin errors++; $display("FAIL tlow pre lock: got %0b expected 1", o_lock); end
      i_pulse = 1'b0;
      repeat (100) @(negedge clk);
      checks += 2;
      if (o_timeout !== 1'b0) begin errors++; $display("FAIL tlow early timeout: got %0b expected 0", o_timeout); end
      if (o_lock !== 1'b1) begin errors++; $display("FAIL tlow early lock: got %0b expected 1", o_lock); end
      repeat (100) @(negedge clk);
      checks += 6;
      if (o_timeout !== 1'b1) begin errors++; $display("FAIL tlow timeout: got %0b expected 1", o_timeout); end
      if (o_lock !== 1'b0) begin errors++; $display("FAIL tlow lock: got %0b expected 0", o_lock); end
      if (q_per.size() !== 5) begin errors++; $display("FAIL tlow count: got %0d expected 5", q_per.size()); end
      if (o_period !== 7'd7) begin errors++; $display("FAIL tlow held per: got %0d expected 7", o_period); end
      if (o_duration !== 7'd3) begin errors++; $display("FAIL tlow held dur: got %0d expected 3", o_duration); end
      if (o_match !== 1'b1) begin errors++; $display("FAIL tlow held match: got %0b expected 1", o_match); end
      clear_q();
      ph = {3, 3};
      pl = {4, 4};
      @(negedge clk) i_pulse = 1'b1;
      repeat (2) @(negedge clk);
      @(negedge clk);
      checks += 2;
      if (o_timeout !== 1'b0) begin errors++; $display("FAIL tlow clear on rise: got %0b expected 0", o_timeout); end
      if (q_per.size() !== 0) begin errors++; $display("FAIL tlow first rise report: got %0d expected 0", q_per.size()); end
      i_pulse = 1'b0;
      repeat (3) @(negedge clk);
      play(1);
      checks++;
      if (q_per.size() !== 2) begin errors++; $display("FAIL tlow restart count: got %0d expected 2", q_per.size()); end
      else begin
         checks += 4;
         if (q_dur[0] !== 3) begin errors++; $display("FAIL tlow restart dur: got %0d expected 3", q_dur[0]); end
         if (q_per[0] !== 7) begin errors++; $display("FAIL tlow restart per: got %0d expected 7", q_per[0]); end
         if (q_match[0] !== 1) begin errors++; $display("FAIL tlow restart match: got %0d expected 1", q_match[0]); end
         if (q_lock[1] !== 0) begin errors++; $display("FAIL tlow restart lock: got %0d expected 0", q_lock[1]); end
      end
   endtask

   task automatic test_timeout_high();
      do_reset();
      ph = {3, 3, 3, 3, 3};
      pl = {4, 4, 4, 4, 4};
      play(0);
      repeat (100) @(negedge clk);
      checks += 2;
      if (o_timeout !== 1'b0) begin errors++; $display("FAIL thigh early timeout: got %0b expected 0", o_timeout); end
      if (o_lock !== 1'b1) begin errors++; $display("FAIL thigh early lock: got %0b expected 1", o_lock); end
      repeat (100) @(negedge clk);
      checks += 3;
      if (o_timeout !== 1'b1) begin errors++; $display("FAIL thigh timeout: got %0b expected 1", o_timeout); end
      if (o_lock !== 1'b0) begin errors++; $display("FAIL thigh lock: got %0b expected 0", o_lock); end
      if (q_per.size() !== 5) begin errors++; $display("FAIL thigh count: got %0d expected 5", q_per.size()); end
      @(negedge clk) i_pulse = 1'b0;
      repeat (4) @(negedge clk);
      clear_q();
      ph = {3, 3};
      pl = {4, 4};
      play(0);
      checks += 2;
      if (o_timeout !== 1'b0) begin errors++; $display("FAIL thigh restart timeout: got %0b expected 0", o_timeout); end
      if (q_per.size() !== 2) begin errors++; $display("FAIL thigh restart count: got %0d expected 2", q_per.size()); end
      else begin
         checks += 3;
         if (q_dur[0] !== 3) begin errors++; $display("FAIL thigh restart dur: got %0d expected 3", q_dur[0]); end
         if (q_per[0] !== 7) begin errors++; $display("FAIL thigh restart per: got %0d expected 7", q_per[0]); end
         if (q_match[1] !== 1) begin errors++; $display("FAIL thigh restart match: got %0d expected 1", q_match[1]); end
      end
   endtask

   task automatic test_period_limit();
      do_reset();
      ph = {3, 3};
      pl = {124, 124};
      play(0);
      checks += 2;
      if (q_per.size() !== 2) begin errors++; $display("FAIL limit127 count: got %0d expected 2", q_per.size()); end
      if (o_timeout !== 1'b0) begin errors++; $display("FAIL limit127 timeout: got %0b expected 0", o_timeout); end
      for (int i = 0; i < q_per.size() && i < 2; i++) begin
         checks += 3;
         if (q_per[i] !== 127) begin errors++; $display("FAIL limit127 per[%0d]: got %0d expected 127", i, q_per[i]); end
         if (q_dur[i] !== 3) begin errors++; $display("FAIL limit127 dur[%0d]: got %0d expected 3", i, q_dur[i]); end
         if (q_match[i] !== 0) begin errors++; $display("FAIL limit127 match[%0d]: got %0d expected 0", i, q_match[i]); end
      end
      do_reset();
      ph = {3};
      pl = {125};
      play(0);
      checks += 3;
      if (q_per.size() !== 0) begin errors++; $display("FAIL limit128 count: got %0d expected 0", q_per.size()); end
      if (o_period !== 7'd0) begin errors++; $display("FAIL limit128 per: got %0d expected 0", o_period); end
      if (o_timeout !== 1'b0) begin errors++; $display("FAIL limit128 timeout: got %0b expected 0", o_timeout); end
   endtask

   task automatic test_async_reset();
      string tag = "asyncrst";
      int ep, em, mc;
      do_reset();
      ph = {3, 3, 3};
      pl = {4, 4, 4};
      play(0);
      checks += 2;
      if (o_match !== 1'b1) begin errors++; $display("FAIL %s pre match: got %0b expected 1", tag, o_match); end
      if (o_period !== 7'd7) begin errors++; $display("FAIL %s pre per: got %0d expected 7", tag, o_period); end
      #2 rst_n = 1'b0;
      #1;
      checks += 4;
      if (o_duration !== 7'd0) begin errors++; $display("FAIL %s dur: got %0d expected 0", tag, o_duration); end
      if (o_period !== 7'd0) begin errors++; $display("FAIL %s per: got %0d expected 0", tag, o_period); end
      if (o_match !== 1'b0) begin errors++; $display("FAIL %s match: got %0b expected 0", tag, o_match); end
      if (o_valid !== 1'b0) begin errors++; $display("FAIL %s valid: got %0b expected 0", tag, o_valid); end
      i_pulse = 1'b0;
      repeat (2) @(negedge clk);
      #3 rst_n = 1'b1;
      clear_q();
      ph = {3};
      pl = {4};
      play(0);
      mc = 0;
      checks++;
      if (q_per.size() !== ph.size()) begin errors++; $display("FAIL %s count: got %0d expected %0d", tag, q_per.size(), ph.size()); end
      for (int i = 0; i < q_per.size() && i < ph.size(); i++) begin
         ep = ph[i] + pl[i];
         em = (ph[i] == 3 && ep == 7) ? 1 : 0;
         mc = em ? ((mc < 4) ? mc + 1 : 4) : 0;
         checks += 4;
         if (q_dur[i] !== ph[i]) begin errors++; $display("FAIL %s dur[%0d]: got %0d expected %0d", tag, i, q_dur[i], ph[i]); end
         if (q_per[i] !== ep) begin errors++; $display("FAIL %s per[%0d]: got %0d expected %0d", tag, i, q_per[i], ep); end
         if (q_match[i] !== em) begin errors++; $display("FAIL %s match[%0d]: got %0d expected %0d", tag, i, q_match[i], em); end
         if (q_lock[i] !== int'(mc == 4)) begin errors++; $display("FAIL %s lock[%0d]: got %0d expected %0d", tag, i, q_lock[i], mc == 4); end
      end
   endtask

   task automatic test_reset_high();
      @(negedge clk) rst_n = 1'b0;
      i_pulse = 1'b1;
      repeat (3) @(negedge clk);
      clear_q();
      ph = {3, 3};
      pl = {4, 4};
      @(negedge clk) rst_n = 1'b1;
      repeat (2) @(negedge clk);
      @(negedge clk) i_pulse = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (q_per.size() !== 0) begin errors++; $display("FAIL rsthigh early report: got %0d expected 0", q_per.size()); end
      play(1);
      checks++;
      if (q_per.size() !== 2) begin errors++; $display("FAIL rsthigh count: got %0d expected 2", q_per.size()); end
      else begin
         checks += 4;
         if (q_dur[0] !== 3) begin errors++; $display("FAIL rsthigh dur: got %0d expected 3", q_dur[0]); end
         if (q_per[0] !== 7) begin errors++; $display("FAIL rsthigh per: got %0d expected 7", q_per[0]); end
         if (q_match[0] !== 1) begin errors++; $display("FAIL rsthigh match: got %0d expected 1", q_match[0]); end
         if (q_cyc[1] - q_cyc[0] !== 7) begin errors++; $display("FAIL rsthigh gap: got %0d expected 7", q_cyc[1] - q_cyc[0]); end
      end
   endtask

   initial begin
      test_reset();
      test_lock();
      test_mismatch();
      test_stretch();
      test_timeout_low();
      test_timeout_high();
      test_period_limit();
      test_async_reset();
      test_reset_high();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pulse_analyzer.md
Name: pulse_analyzer

Overview:
Receive-side counterpart of the team's periodic pulse generator. It synchronises an incoming pulse train and measures high time and period in i_clk cycles. Each completed period is reported with a one-cycle strobe and compared against expected values. It tracks lock state and flags a timeout when edges stop arriving.

Parameters:
CNT_W, 7, width of the duration/period counters and reported values (max period of interest is 100 clks)
EXP_DURATION, 3, expected high time in clocks, used for o_match
EXP_PERIOD, 7, expected period in clocks, used for o_match
TIMEOUT, 127, period-counter value at which measurement is abandoned; must be <= 2^CNT_W-1 and > EXP_PERIOD
LOCK_COUNT, 4, consecutive matching periods required to assert o_lock (1..15)

Ports:
i_clk  input  1  single clock; all logic on rising edge
i_rst_n  input  1  asynchronous, active-low reset
i_pulse  input  1  pulse train; asynchronous to i_clk, may glitch-free toggle at any time
o_duration  output  CNT_W  high time of last completed period
o_period  output  CNT_W  length of last completed period
o_valid  output  1  one-cycle strobe: o_duration/o_period/o_match updated this cycle
o_match  output  1  last period equalled EXP_DURATION and EXP_PERIOD
o_lock  output  1  LOCK_COUNT consecutive matches seen, no mismatch/timeout since
o_timeout  output  1  sticky timeout flag, cleared on next detected rise

Behaviour:
- Reset (i_rst_n low, async): sync flops, edge flop, counters, match counter -> 0; state IDLE; all outputs 0 immediately, independent of i_clk.
- Input path: 2-flop synchroniser -> s; one delay flop s_d. rise = s & ~s_d, fall = ~s & s_d. Fixed 2-cycle input latency cancels out of all measurements.
- hi_cnt, per_cnt: CNT_W bits, never wrap (bounded by TIMEOUT).
- FSM states IDLE, HIGH, LOW:
  - IDLE: on rise -> HIGH, hi_cnt<=1, per_cnt<=1, o_timeout<=0; no report (no prior period).
  - HIGH: each cycle per_cnt++; s high -> hi_cnt++; on fall -> LOW (hi_cnt holds).
  - LOW: each cycle per_cnt++; on rise -> report, then hi_cnt<=1, per_cnt<=1, stay measuring in HIGH.
- Report (registered, in the cycle after the rise cycle): o_duration<=hi_cnt, o_period<=per_cnt, o_valid=1 for exactly one cycle.
  - o_match <= (hi_cnt==EXP_DURATION && per_cnt==EXP_PERIOD).
  - o_period counts clocks from one rise cycle up to the cycle before the next rise. o_duration counts clocks with s high.
  - Example: a 3-high/7-period train reports 3/7.
- Lock: match_cnt (4 bits) increments on a matching report and saturates at LOCK_COUNT. A mismatching report clears it to 0.
  - o_lock = 1 while match_cnt==LOCK_COUNT, registered in the same cycle as o_valid.
- Timeout: in HIGH or LOW, when per_cnt == TIMEOUT and no rise occurs this cycle:
  - -> IDLE, o_timeout<=1, match_cnt<=0, o_lock<=0, no o_valid.
  - o_duration/o_period/o_match keep their last values.
  - Covers input stuck low and stuck high.
- Simultaneous rise and per_cnt==TIMEOUT: rise wins; report normally with o_period=TIMEOUT.
- Input high at reset release: the synchroniser produces a rise from IDLE. Measurement starts but no report is issued until a full period completes.
- A rise from IDLE after a timeout clears o_timeout. The first o_valid comes only at the second rise.

Test Plan:
- Reset, then a 3-high/7-period train for 10 periods -> o_valid every 7 cycles starting at the 2nd rise; o_duration=3, o_period=7, o_match=1; o_lock=1 on the 4th o_valid and held.
- 2-high/5-period train -> o_valid every 5 cycles; o_duration=2, o_period=5, o_match=0, o_lock=0. Then switch to 3/7 -> o_lock rises on the 4th matching report.
- Locked on 3/7, then one period stretched to 8 -> that report has o_period=8, o_match=0, o_lock=0; o_lock returns after 4 further 3/7 periods.
- Locked, then i_pulse held low (and, separately, held high) for 200 cycles -> o_timeout=1 when per_cnt hits 127, o_lock=0, no o_valid. Restart 3/7 -> o_timeout clears on the first rise; first o_valid at the second rise reports 3/7.
- i_rst_n pulsed low mid-HIGH, asynchronous to i_clk -> all outputs 0 before the next i_clk edge. After release, the 3/7 train gives its first report after one full period.
- i_pulse high throughout reset release -> no o_valid until after the next full low-high period. The first report is a correct 3/7.
